posit_add_scheduler: RTL

- Shares one fixed-latency posit adder pipeline (add stage plus rounding stage) between NREQ requesters.
- Round-robin arbitration on a valid/ready request interface.
- Tracks requester ID through the pipeline and returns tagged results on one shared response channel.
- Uses a result FIFO and credit counting, so the adder pipeline never stalls and no result is dropped.

---
 rtl/posit_add_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/posit_add_scheduler.sv
// Round-robin scheduler sharing one fixed-latency posit adder between NREQ requesters.
// Results are tagged with the requester index and returned in issue order through a credited FIFO.
module posit_add_scheduler #(
    parameter int unsigned N     = 32,
    parameter int unsigned ES    = 2,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LAT   = 3,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned IDW  = $clog2(NREQ),
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_in1,
    input  logic [NREQ*N-1:0] req_in2,
    output logic [N-1:0]      add_in1,
    output logic [N-1:0]      add_in2,
    output logic              add_issue,
    input  logic [N-1:0]      add_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic [CW-1:0]     credits_used
);

    localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
    localparam logic [PW-1:0] LastSlot = PW'(DEPTH - 1);

    if (NREQ < 2 || LAT < 1 || DEPTH < 1 || ES >= N) begin : g_bad_cfg
        $error("posit_add_scheduler: invalid parameter set");
    end

    logic [IDW-1:0] ptr_q, ptr_d, gnt_idx;
    logic           gnt_any, can_issue, issue, pop, push;
    logic [CW-1:0]  cred_q, cred_d, count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic           tag_v_q  [LAT];
    logic           tag_v_d  [LAT];
    logic [IDW-1:0] tag_id_q [LAT];
    logic [IDW-1:0] tag_id_d [LAT];
    logic [N-1:0]   mem_data_q [DEPTH];
    logic [N-1:0]   mem_data_d [DEPTH];
    logic [IDW-1:0] mem_id_q   [DEPTH];
    logic [IDW-1:0] mem_id_d   [DEPTH];

    assign rsp_valid    = (count_q != '0);
    assign rsp_data     = rsp_valid ? mem_data_q[rd_ptr_q] : '0;
    assign rsp_id       = rsp_valid ? mem_id_q[rd_ptr_q] : '0;
    assign credits_used = cred_q;
    assign pop          = rsp_valid && rsp_ready;
    assign push         = tag_v_q[LAT-1];
    // A pop in the same cycle frees the slot the new issue will eventually need.
    assign can_issue    = (cred_q < DepthC) || ((cred_q == DepthC) && pop);

    // Descending scan so the candidate nearest to ptr+1 is the one that sticks.
    always_comb begin
        int cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(ptr_q) + k) % int'(NREQ);
            if (req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        issue     = gnt_any && can_issue && !reset;
        req_ready = '0;
        add_in1   = '0;
        add_in2   = '0;
        ptr_d     = ptr_q;
        if (issue) begin
            req_ready[gnt_idx] = 1'b1;
            add_in1            = req_in1[int'(gnt_idx)*N +: N];
            add_in2            = req_in2[int'(gnt_idx)*N +: N];
            ptr_d              = gnt_idx;
        end
        add_issue = issue;
    end

    always_comb begin
        tag_v_d[0]  = issue;
        tag_id_d[0] = gnt_idx;
        for (int k = 1; k < LAT; k++) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_id_d[k] = tag_id_q[k-1];
        end
    end

    always_comb begin
        cred_d     = cred_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_data_d = mem_data_q;
        mem_id_d   = mem_id_q;
        if (issue && !pop) cred_d = cred_q + 1'b1;
        else if (!issue && pop) cred_d = cred_q - 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        if (push) begin
            mem_data_d[wr_ptr_q] = add_out;
            mem_id_d[wr_ptr_q]   = tag_id_q[LAT-1];
            wr_ptr_d             = (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= IDW'(NREQ - 1);
            cred_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_v_q[k]  <= 1'b0;
                tag_id_q[k] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            cred_q   <= cred_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int k = 0; k < LAT; k++) begin
                tag_v_q[k]  <= tag_v_d[k];
                tag_id_q[k] <= tag_id_d[k];
            end
        end
    end

    // Storage needs no reset: rsp_data/rsp_id are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_data_q <= mem_data_d;
        mem_id_q   <= mem_id_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && (count_q == DepthC) && !pop));
        end
    end

endmodule
